ether_rx_driver: RTL and testbench

Receive-side counterpart of the MII transmit driver. It samples the 4-bit MII receive interface, checks the preamble/SFD nibble pattern and the IPv4 ethertype, and assembles the nibble stream MSB-first into one frame-wide vector. Accepted frames go out through a single-entry valid/ready holding buffer to the upstream frame consumer. Errored frames are dropped and reported with an error code.

---
 rtl/ether_rx_driver.sv | 168 ++++++++++++++++
 tb/tb_ether_rx_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ether_rx_driver.sv
// MII receive driver: checks preamble/SFD and IPv4 ethertype, assembles nibbles MSB-first,
// and hands accepted frames to a single-entry valid/ready buffer; rejected frames raise an error strobe.
module ether_rx_driver #(
  parameter int  ETH_MAX_FRAME_SIZE = 256,
  parameter int  PREAMBLE_NIBBLES   = 16,
  localparam int MAX_NIB            = ETH_MAX_FRAME_SIZE / 4,
  localparam int LEN_W              = $clog2(MAX_NIB) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    mii_rxd,
  input  logic                          mii_rx_dv,
  input  logic                          mii_rx_err,
  output logic [ETH_MAX_FRAME_SIZE-1:0] rx_drv_rd_data,
  output logic [LEN_W-1:0]              rx_drv_rd_len,
  output logic                          rx_drv_rd_valid,
  input  logic                          rx_drv_rd_ready,
  output logic                          rx_err_strobe,
  output logic [2:0]                    rx_err_code,
  output logic [7:0]                    rx_drop_count
);

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_PRE   = 3'd1;
  localparam logic [2:0] ERR_ETYPE = 3'd2;
  localparam logic [2:0] ERR_MII   = 3'd3;
  localparam logic [2:0] ERR_SHORT = 3'd4;
  localparam logic [2:0] ERR_LONG  = 3'd5;
  localparam logic [2:0] ERR_OVF   = 3'd6;

  localparam int P        = PREAMBLE_NIBBLES;
  localparam int MIN_NIB  = P + 28;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DISCARD} state_t;

  state_t                        state_q, state_d;
  logic [LEN_W-1:0]              idx_q, idx_d;
  logic [ETH_MAX_FRAME_SIZE-1:0] asm_q, asm_d;
  logic [2:0]                    disc_code_q, disc_code_d;
  logic [ETH_MAX_FRAME_SIZE-1:0] buf_dat_q, buf_dat_d;
  logic [LEN_W-1:0]              buf_len_q, buf_len_d;
  logic                          buf_vld_q, buf_vld_d;
  logic                          strobe_q, strobe_d;
  logic [2:0]                    code_q, code_d;
  logic [7:0]                    drop_q, drop_d;

  logic [2:0] frame_err;
  logic [2:0] end_reject;
  logic       commit;
  logic [2:0] nib_code;

  // Expected-pattern check for the nibble landing at position pos.
  function automatic logic [2:0] nib_check(input logic [LEN_W-1:0] pos, input logic [3:0] nib);
    logic [2:0] c;
    c = ERR_NONE;
    if (pos < LEN_W'(P - 1)) begin
      if (nib != 4'hA) c = ERR_PRE;
    end else if (pos == LEN_W'(P - 1)) begin
      if (nib != 4'hB) c = ERR_PRE;
    end else if (pos == LEN_W'(P + 25)) begin
      if (nib != 4'h8) c = ERR_ETYPE;
    end else if (pos >= LEN_W'(P + 24) && pos <= LEN_W'(P + 27)) begin
      if (nib != 4'h0) c = ERR_ETYPE;
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    frame_err  = ERR_NONE;
    end_reject = ERR_NONE;
    commit     = 1'b0;
    nib_code   = nib_check(idx_q, mii_rxd);
    case (state_q)
      S_IDLE: begin
        if (mii_rx_dv) begin
          frame_err = mii_rx_err ? ERR_MII : nib_code;
          state_d   = (frame_err != ERR_NONE) ? S_DISCARD : S_RECV;
        end
      end
      S_RECV: begin
        if (mii_rx_dv) begin
          if (idx_q == LEN_W'(MAX_NIB)) frame_err = ERR_LONG;
          else if (mii_rx_err)          frame_err = ERR_MII;
          else                          frame_err = nib_code;
          if (frame_err != ERR_NONE) state_d = S_DISCARD;
        end else begin
          state_d = S_IDLE;
          if (idx_q < LEN_W'(MIN_NIB))                 end_reject = ERR_SHORT;
          else if (buf_vld_q && !rx_drv_rd_ready)      end_reject = ERR_OVF;
          else                                         commit     = 1'b1;
        end
      end
      S_DISCARD: begin
        if (!mii_rx_dv) begin
          state_d    = S_IDLE;
          end_reject = disc_code_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d       = '0;
    asm_d       = '0;
    disc_code_d = (frame_err != ERR_NONE) ? frame_err : disc_code_q;
    if ((state_q == S_IDLE || state_q == S_RECV) && mii_rx_dv && state_d == S_RECV) begin
      asm_d = (state_q == S_IDLE) ? '0 : asm_q;
      for (int n = 0; n < MAX_NIB; n++) begin
        if (n == int'(idx_q)) asm_d[ETH_MAX_FRAME_SIZE-1-4*n -: 4] = mii_rxd;
      end
      idx_d = idx_q + LEN_W'(1);
    end

    buf_dat_d = buf_dat_q;
    buf_len_d = buf_len_q;
    buf_vld_d = buf_vld_q;
    if (commit) begin
      buf_dat_d = asm_q;
      buf_len_d = idx_q;
      buf_vld_d = 1'b1;
    end else if (buf_vld_q && rx_drv_rd_ready) begin
      buf_vld_d = 1'b0;
    end

    strobe_d = (end_reject != ERR_NONE);
    code_d   = strobe_d ? end_reject : code_q;
    drop_d   = (strobe_d && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      asm_q       <= '0;
      disc_code_q <= ERR_NONE;
      buf_dat_q   <= '0;
      buf_len_q   <= '0;
      buf_vld_q   <= 1'b0;
      strobe_q    <= 1'b0;
      code_q      <= ERR_NONE;
      drop_q      <= '0;
    end else begin
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      disc_code_q <= disc_code_d;
      buf_dat_q   <= buf_dat_d;
      buf_len_q   <= buf_len_d;
      buf_vld_q   <= buf_vld_d;
      strobe_q    <= strobe_d;
      code_q      <= code_d;
      drop_q      <= drop_d;
    end
  end

  assign rx_drv_rd_data  = buf_dat_q;
  assign rx_drv_rd_len   = buf_len_q;
  assign rx_drv_rd_valid = buf_vld_q;
  assign rx_err_strobe   = strobe_q;
  assign rx_err_code     = code_q;
  assign rx_drop_count   = drop_q;

endmodule

// File: tb/tb_ether_rx_driver.sv
// Directed bench for ether_rx_driver: hand-built MII frames with expected data/len/error codes.
module tb_ether_rx_driver;
  localparam int W  = 256;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    mii_rxd;
  logic          mii_rx_dv;
  logic          mii_rx_err;
  logic [W-1:0]  rd_data;
  logic [LW-1:0] rd_len;
  logic          rd_valid;
  logic          rd_ready;
  logic          err_strobe;
  logic [2:0]    err_code;
  logic [7:0]    drop_count;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [3:0]    fr [128];
  int            fr_len;
  logic [W-1:0]  exp_a;

  always #5 clk = ~clk;

  ether_rx_driver dut (
    .clk             (clk),
    .rst             (rst),
    .mii_rxd         (mii_rxd),
    .mii_rx_dv       (mii_rx_dv),
    .mii_rx_err      (mii_rx_err),
    .rx_drv_rd_data  (rd_data),
    .rx_drv_rd_len   (rd_len),
    .rx_drv_rd_valid (rd_valid),
    .rx_drv_rd_ready (rd_ready),
    .rx_err_strobe   (err_strobe),
    .rx_err_code     (err_code),
    .rx_drop_count   (drop_count)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are read at the same point.
  task automatic drive(input logic dv, input logic [3:0] nib, input logic er);
    mii_rx_dv  = dv;
    mii_rxd    = nib;
    mii_rx_err = er;
    @(posedge clk);
    #1;
  endtask

  task automatic build(input int n, input int variant);
    fr_len = n;
    for (int i = 0; i < n; i++) begin
      if (i < 15)       fr[i] = 4'hA;
      else if (i == 15) fr[i] = 4'hB;
      else if (i < 40)  fr[i] = 4'(i * 7 + variant);
      else if (i == 41) fr[i] = 4'h8;
      else if (i < 44)  fr[i] = 4'h0;
      else              fr[i] = 4'(i * 5 + variant);
    end
  endtask

  function automatic logic [W-1:0] model();
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < fr_len && i < 64; i++) m[W-1-4*i -: 4] = fr[i];
    return m;
  endfunction

  task automatic send_nibs(input int err_at);
    for (int i = 0; i < fr_len; i++) drive(1'b1, fr[i], i == err_at);
  endtask

  task automatic send_frame(input int err_at);
    send_nibs(err_at);
    drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic chk_reject(input string tag, input int code, input int drops);
    chk({tag, "_strobe"}, W'(err_strobe), W'(1));
    chk({tag, "_code"},   W'(err_code),   W'(code));
    chk({tag, "_drop"},   W'(drop_count), W'(drops));
    chk({tag, "_valid"},  W'(rd_valid),   W'(0));
  endtask

  initial begin
    logic [W-1:0] d;
    rst        = 1'b1;
    mii_rxd    = 4'h0;
    mii_rx_dv  = 1'b0;
    mii_rx_err = 1'b0;
    rd_ready   = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid",  W'(rd_valid),   W'(0));
    chk("rst_data",   rd_data,        '0);
    chk("rst_len",    W'(rd_len),     W'(0));
    chk("rst_strobe", W'(err_strobe), W'(0));
    chk("rst_code",   W'(err_code),   W'(0));
    chk("rst_drop",   W'(drop_count), W'(0));
    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0);

    // Good 64-nibble frame
    build(64, 0);
    send_frame(-1);
    chk("good_valid",  W'(rd_valid),   W'(1));
    chk("good_len",    W'(rd_len),     W'(64));
    chk("good_data",   rd_data,        model());
    chk("good_strobe", W'(err_strobe), W'(0));
    drive(1'b0, 4'h0, 1'b0);
    chk("good_drain",  W'(rd_valid),   W'(0));

    // Minimum-length frame
    build(44, 3);
    send_frame(-1);
    chk("min_valid",  W'(rd_valid),   W'(1));
    chk("min_len",    W'(rd_len),     W'(44));
    chk("min_data",   rd_data,        model());
    d = rd_data;
    chk("min_tail0",  W'(d[79:0]),    W'(0));
    chk("min_strobe", W'(err_strobe), W'(0));
    drive(1'b0, 4'h0, 1'b0);

    build(43, 3);
    send_frame(-1);
    chk_reject("short", 4, 1);
    drive(1'b0, 4'h0, 1'b0);
    chk("strobe_1cyc", W'(err_strobe), W'(0));
    chk("code_held",   W'(err_code),   W'(4));

    build(64, 1);
    fr[5] = 4'h5;
    send_frame(-1);
    chk_reject("pre", 1, 2);

    build(64, 1);
    fr[40] = 4'h8; fr[41] = 4'h6; fr[42] = 4'hD; fr[43] = 4'hD;
    send_frame(-1);
    chk_reject("etype", 2, 3);

    build(70, 2);
    send_frame(-1);
    chk_reject("long", 5, 4);

    // Held buffer and overflow
    rd_ready = 1'b0;
    build(64, 4);
    exp_a = model();
    send_frame(-1);
    chk("hold_valid", W'(rd_valid), W'(1));
    build(50, 5);
    send_frame(-1);
    chk("ovf_strobe", W'(err_strobe), W'(1));
    chk("ovf_code",   W'(err_code),   W'(6));
    chk("ovf_drop",   W'(drop_count), W'(5));
    chk("ovf_valid",  W'(rd_valid),   W'(1));
    chk("ovf_data",   rd_data,        exp_a);
    chk("ovf_len",    W'(rd_len),     W'(64));
    build(48, 6);
    send_nibs(-1);
    chk("pre_c_data", rd_data, exp_a);
    rd_ready = 1'b1;
    drive(1'b0, 4'h0, 1'b0);
    chk("c_valid",  W'(rd_valid),   W'(1));
    chk("c_len",    W'(rd_len),     W'(48));
    chk("c_data",   rd_data,        model());
    chk("c_strobe", W'(err_strobe), W'(0));
    chk("c_drop",   W'(drop_count), W'(5));
    drive(1'b0, 4'h0, 1'b0);
    chk("c_drain",  W'(rd_valid),   W'(0));

    build(64, 7);
    send_frame(30);
    chk_reject("mii_err", 3, 6);

    // Saturation of the drop counter
    build(1, 0);
    for (int k = 0; k < 249; k++) send_frame(-1);
    chk("drop_at_255", W'(drop_count), W'(255));
    for (int k = 0; k < 7; k++) send_frame(-1);
    chk("drop_sat",    W'(drop_count), W'(255));
    chk("sat_code",    W'(err_code),   W'(4));

    // Reset in the middle of a frame
    build(64, 8);
    for (int i = 0; i < 20; i++) drive(1'b1, fr[i], 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_drop",   W'(drop_count), W'(0));
    chk("mid_rst_code",   W'(err_code),   W'(0));
    chk("mid_rst_valid",  W'(rd_valid),   W'(0));
    chk("mid_rst_strobe", W'(err_strobe), W'(0));
    chk("mid_rst_len",    W'(rd_len),     W'(0));
    drive(1'b1, 4'hA, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0);
    chk("post_rst_strobe", W'(err_strobe), W'(0));
    build(64, 9);
    send_frame(-1);
    chk("post_rst_valid", W'(rd_valid),   W'(1));
    chk("post_rst_len",   W'(rd_len),     W'(64));
    chk("post_rst_data",  rd_data,        model());
    chk("post_rst_drop",  W'(drop_count), W'(0));
    chk("post_rst_stb",   W'(err_strobe), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
